sprite_dma_sched: RTL and testbench

//  Per-line scheduler for the shared font/sprite graphics ROM. Replaces fixed
//  per-sprite sx windows: during horizontal blanking, grants each requesting

---
 rtl/projf_sprite_pkg.sv | 6 +
 rtl/sprite_dma_sched_rr_pick.sv | 30 +++
 rtl/sprite_dma_sched.sv | 136 +++++++++++++
 tb/tb_sprite_dma_sched.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/projf_sprite_pkg.sv
// Shared types for the sprite/font ROM scheduling blocks.
// Latency: n/a (types only). Backpressure: n/a.
// Keep the state encoding here so that later arbiters and debug taps agree on it.
package projf_sprite_pkg;
  typedef enum logic [1:0] {IDLE, ARB, GRANT, DONE} sched_state_t;
endpackage

// File: rtl/sprite_dma_sched_rr_pick.sv
// Rotating priority pick: first set bit of vec searching upward from start, with wrap.
// Latency: combinational. Backpressure: none.
// vld=0 when vec is empty; idx is then 0.
module rr_pick #(
  parameter int N  = 5,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  vec,
  input  logic [IW-1:0] start,
  output logic          vld,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] cand;

  // Walk from the farthest candidate back to start so the nearest hit wins.
  always_comb begin
    vld  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = IW'((int'(start) + k) % N);
      if (vec[cand]) begin
        vld = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/sprite_dma_sched.sv
// Per-line blanking scheduler: grants requesting sprites back-to-back ROM DMA slots.
// Latency: first grant at sx==HACTIVE+1, each slot DMA_CYC clocks; rom_addr is same-cycle.
// Backpressure: none; a started slot always runs its full length, unfit slots are dropped as overrun.
module sprite_dma_sched
  import projf_sprite_pkg::*;
#(
  parameter int NSPR    = 5,
  parameter int ADDRW   = 11,
  parameter int CORDW   = 12,
  parameter int HACTIVE = 1280,
  parameter int WINDOW  = 64,
  parameter int DMA_CYC = 2
) (
  input  logic                  clk_pix,
  input  logic                  rstn_i,
  input  logic [CORDW-1:0]      sx,
  input  logic                  en,
  input  logic [NSPR-1:0]       req,
  input  logic [NSPR*ADDRW-1:0] gfx_addr,
  output logic [NSPR-1:0]       dma_avail,
  output logic [ADDRW-1:0]      rom_addr,
  output logic                  busy,
  output logic                  overrun,
  output logic [NSPR-1:0]       served
);

  localparam int IW      = (NSPR > 1) ? $clog2(NSPR) : 1;
  localparam int CW      = (DMA_CYC > 1) ? $clog2(DMA_CYC) : 1;
  localparam int LAST_SX = HACTIVE + WINDOW - 1;

  sched_state_t    state;
  logic [NSPR-1:0] pending, slot_served, pick_vec, g_oh;
  logic [IW-1:0]   rr_ptr, g, pick_idx;
  logic [CW-1:0]   slot_cnt;
  logic            pick_vld, slot_fits, win_open, early_exit, slot_last;

  assign g_oh       = NSPR'(1) << g;
  // A slot decided now starts next clock and must end by the window's last sx.
  assign slot_fits  = (int'(sx) + DMA_CYC) <= LAST_SX;
  assign win_open   = (int'(sx) == HACTIVE) && en;
  assign early_exit = int'(sx) < HACTIVE;
  assign slot_last  = slot_cnt == CW'(DMA_CYC - 1);
  assign busy       = (state == ARB) || (state == GRANT);

  always_comb begin
    pick_vec = pending;
    case (state)
      IDLE:    pick_vec = req;
      GRANT:   pick_vec = pending & ~g_oh;
      default: pick_vec = pending;
    endcase
  end

  rr_pick #(.N(NSPR), .IW(IW)) u_pick (
    .vec   (pick_vec),
    .start (rr_ptr),
    .vld   (pick_vld),
    .idx   (pick_idx)
  );

  always_comb begin
    rom_addr = '0;
    for (int i = 0; i < NSPR; i++)
      if (dma_avail[i]) rom_addr = rom_addr | gfx_addr[i*ADDRW +: ADDRW];
  end

  // The window-open cycle performs the arbitration pick itself so the first
  // grant lands at HACTIVE+1; ARB re-arbitrates from pending if ever entered.
  always_ff @(posedge clk_pix or negedge rstn_i) begin
    if (!rstn_i) begin
      state       <= IDLE;
      pending     <= '0;
      slot_served <= '0;
      rr_ptr      <= '0;
      g           <= '0;
      slot_cnt    <= '0;
      dma_avail   <= '0;
      overrun     <= 1'b0;
      served      <= '0;
    end else begin
      overrun <= 1'b0;
      case (state)
        IDLE: begin
          if (win_open) begin
            pending     <= req;
            slot_served <= '0;
            if (pick_vld && slot_fits) begin
              g         <= pick_idx;
              dma_avail <= NSPR'(1) << pick_idx;
              slot_cnt  <= '0;
              state     <= GRANT;
            end else begin
              state <= DONE;
              if (pick_vld) begin
                overrun <= 1'b1;
                rr_ptr  <= pick_idx;
              end
            end
          end
        end
        ARB, GRANT: begin
          if (early_exit) begin
            state     <= IDLE;
            dma_avail <= '0;
          end else if (state == ARB || slot_last) begin
            if (state == GRANT) begin
              pending     <= pending & ~g_oh;
              slot_served <= slot_served | g_oh;
            end
            if (pick_vld && slot_fits) begin
              g         <= pick_idx;
              dma_avail <= NSPR'(1) << pick_idx;
              slot_cnt  <= '0;
              state     <= GRANT;
            end else begin
              dma_avail <= '0;
              state     <= DONE;
              if (pick_vld) begin
                overrun <= 1'b1;
                rr_ptr  <= pick_idx;
              end
            end
          end else begin
            slot_cnt <= slot_cnt + 1'b1;
          end
        end
        DONE: begin
          served <= slot_served;
          if (sx == '0) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_dma_sched.sv
// Scoreboard bench for sprite_dma_sched: a 64-clock window instance and a 6-clock window instance.
module tb_sprite_dma_sched;
  localparam int NSPR  = 5;
  localparam int ADDRW = 11;
  localparam int CORDW = 12;

  logic                  clk_pix = 1'b0;
  logic                  rstn_i;
  logic [CORDW-1:0]      sx;
  logic                  en;
  logic [NSPR-1:0]       req;
  logic [NSPR*ADDRW-1:0] gfx_addr;
  logic [NSPR-1:0]       dma_avail, served, w_dma_avail, w_served;
  logic [ADDRW-1:0]      rom_addr, w_rom_addr;
  logic                  busy, overrun, w_busy, w_overrun;

  typedef struct {
    int sx;
    int idx;
  } exp_t;

  exp_t exp_q[$];
  exp_t exp_w[$];
  int   ovr_w[$];
  exp_t m_e, w_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic chk_w   = 1'b0;

  sprite_dma_sched #(.NSPR(NSPR), .ADDRW(ADDRW), .CORDW(CORDW), .HACTIVE(1280),
                     .WINDOW(64), .DMA_CYC(2)) dut (
    .clk_pix(clk_pix), .rstn_i(rstn_i), .sx(sx), .en(en), .req(req), .gfx_addr(gfx_addr),
    .dma_avail(dma_avail), .rom_addr(rom_addr), .busy(busy), .overrun(overrun), .served(served)
  );

  sprite_dma_sched #(.NSPR(NSPR), .ADDRW(ADDRW), .CORDW(CORDW), .HACTIVE(1280),
                     .WINDOW(6), .DMA_CYC(2)) dut_w (
    .clk_pix(clk_pix), .rstn_i(rstn_i), .sx(sx), .en(en), .req(req), .gfx_addr(gfx_addr),
    .dma_avail(w_dma_avail), .rom_addr(w_rom_addr), .busy(w_busy), .overrun(w_overrun),
    .served(w_served)
  );

  always #5 clk_pix = ~clk_pix;

  // Each sprite's address moves with sx, so a stale mux would show up.
  function automatic logic [ADDRW-1:0] addr_for(input int i, input int s);
    return ADDRW'(256 + i * 64 + (s % 16));
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (sx=%0d)", nm, act, exp, sx);
    end
  endtask

  task automatic step(input int s);
    @(posedge clk_pix);
    #1;
    sx = CORDW'(s);
    for (int i = 0; i < NSPR; i++) gfx_addr[i*ADDRW +: ADDRW] = addr_for(i, s);
  endtask

  task automatic push_grant(input int which, input int idx, input int first_sx, input int ncyc);
    exp_t e;
    for (int k = 0; k < ncyc; k++) begin
      e.sx  = first_sx + k;
      e.idx = idx;
      if (which == 0) exp_q.push_back(e);
      else exp_w.push_back(e);
    end
  endtask

  task automatic run_line(input logic [NSPR-1:0] r, input logic e, input int abort_at);
    req = r;
    en  = e;
    for (int s = 1276; s <= 1295; s++) begin
      if (s == abort_at) break;
      step(s);
    end
    for (int s = 0; s < 3; s++) step(s);
    en = 1'b1;
  endtask

  always @(negedge clk_pix) begin
    if (rstn_i) begin
      if (dma_avail != '0) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL grant_unexpected: got dma_avail=%b at sx=%0d expected none", dma_avail, sx);
        end else begin
          m_e = exp_q.pop_front();
          chk("grant_sx", int'(sx), m_e.sx);
          chk("grant_onehot", int'(dma_avail), 1 << m_e.idx);
          chk("grant_rom_addr", int'(rom_addr), int'(addr_for(m_e.idx, m_e.sx)));
          chk("busy_in_grant", int'(busy), 1);
        end
      end else begin
        chk("rom_addr_idle", int'(rom_addr), 0);
        chk("busy_idle", int'(busy), 0);
      end
      chk("overrun_main", int'(overrun), 0);
    end
  end

  always @(negedge clk_pix) begin
    if (rstn_i && chk_w) begin
      if (w_dma_avail != '0) begin
        if (exp_w.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL w_grant_unexpected: got dma_avail=%b at sx=%0d expected none", w_dma_avail, sx);
        end else begin
          w_e = exp_w.pop_front();
          chk("w_grant_sx", int'(sx), w_e.sx);
          chk("w_grant_onehot", int'(w_dma_avail), 1 << w_e.idx);
          chk("w_grant_rom_addr", int'(w_rom_addr), int'(addr_for(w_e.idx, w_e.sx)));
        end
      end else begin
        chk("w_rom_addr_idle", int'(w_rom_addr), 0);
      end
      if (w_overrun) begin
        if (ovr_w.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL w_overrun_unexpected: got pulse at sx=%0d expected none", sx);
        end else begin
          chk("w_overrun_sx", int'(sx), ovr_w.pop_front());
        end
      end
    end
  end

  initial begin
    rstn_i = 1'b0;
    sx     = '0;
    en     = 1'b0;
    req    = '0;
    for (int i = 0; i < NSPR; i++) gfx_addr[i*ADDRW +: ADDRW] = addr_for(i, 0);
    repeat (3) @(posedge clk_pix);
    #1;
    chk("rst_dma_avail", int'(dma_avail), 0);
    chk("rst_rom_addr", int'(rom_addr), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_served", int'(served), 0);
    step(0);
    rstn_i = 1'b1;
    step(1);

    // All five request; the short window fits only sprites 0 and 1.
    chk_w = 1'b1;
    for (int k = 0; k < 5; k++) push_grant(0, k, 1281 + 2 * k, 2);
    push_grant(1, 0, 1281, 2);
    push_grant(1, 1, 1283, 2);
    ovr_w.push_back(1285);
    run_line(5'b11111, 1'b1, -1);
    chk("served_all", int'(served), 31);
    chk("w_served_first", int'(w_served), 3);

    // Starved sprites lead the short window on the following line.
    for (int k = 0; k < 5; k++) push_grant(0, k, 1281 + 2 * k, 2);
    push_grant(1, 2, 1281, 2);
    push_grant(1, 3, 1283, 2);
    ovr_w.push_back(1285);
    run_line(5'b11111, 1'b1, -1);
    chk("served_all_2", int'(served), 31);
    chk("w_served_rotated", int'(w_served), 12);
    chk_w = 1'b0;

    // Sparse request set.
    push_grant(0, 2, 1281, 2);
    push_grant(0, 4, 1283, 2);
    run_line(5'b10100, 1'b1, -1);
    chk("served_sparse", int'(served), 20);

    // sx drops to 0 where 1283 was due: the slot already started shows once, then abort.
    push_grant(0, 0, 1281, 2);
    push_grant(0, 1, 0, 1);
    run_line(5'b11111, 1'b1, 1283);
    chk("served_after_abort", int'(served), 20);

    // Disabled at window open: no grants, served untouched.
    run_line(5'b11111, 1'b0, -1);
    chk("served_en_low", int'(served), 20);
    for (int k = 0; k < 5; k++) push_grant(0, k, 1281 + 2 * k, 2);
    run_line(5'b11111, 1'b1, -1);
    chk("served_en_back", int'(served), 31);

    // Reset in the middle of the first slot.
    req = 5'b11111;
    en  = 1'b1;
    push_grant(0, 0, 1281, 1);
    for (int s = 1276; s <= 1282; s++) step(s);
    #1 rstn_i = 1'b0;
    #1;
    chk("midrst_dma_avail", int'(dma_avail), 0);
    chk("midrst_rom_addr", int'(rom_addr), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_served", int'(served), 0);
    for (int s = 1283; s <= 1285; s++) step(s);
    rstn_i = 1'b1;
    for (int s = 1286; s <= 1295; s++) step(s);
    for (int s = 0; s < 3; s++) step(s);
    chk("served_after_rst", int'(served), 0);

    for (int k = 0; k < 5; k++) push_grant(0, k, 1281 + 2 * k, 2);
    run_line(5'b11111, 1'b1, -1);
    chk("served_post_rst", int'(served), 31);

    repeat (2) step(3);
    chk("exp_q_drained", exp_q.size(), 0);
    chk("exp_w_drained", exp_w.size(), 0);
    chk("ovr_w_drained", ovr_w.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
